// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-tick divider, h/v counters, sync/blank decode,
// a PIPE-deep alignment line for the source latency, and registered VGA pins.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int COLOR_W  = 4,
    parameter int PIPE     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               pix_req,
    output logic [10:0]        pix_x,
    output logic [9:0]         pix_y,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    output logic               VGA_H_SYNC,
    output logic               VGA_V_SYNC,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               line_start,
    output logic               frame_start,
    output logic [15:0]        frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]   div_r;
    logic [10:0]        h_r;
    logic [9:0]         v_r;
    logic [15:0]        frame_count_r;
    logic               tick_s;
    logic               h_wrap_s;
    logic               v_wrap_s;
    logic               de_s;
    logic               hs_s;
    logic               vs_s;
    logic [2:0]         cur_s;
    logic [2:0]         late_s;
    logic               hsync_r;
    logic               vsync_r;
    logic [COLOR_W-1:0] red_r;
    logic [COLOR_W-1:0] grn_r;
    logic [COLOR_W-1:0] blu_r;
    logic               line_start_r;
    logic               frame_start_r;

    // Tick qualification and count decode from the current (h,v)
    always_comb begin
        tick_s   = en && (div_r == DIV_W'(CLK_DIV - 1));
        h_wrap_s = (h_r == 11'(H_TOTAL - 1));
        v_wrap_s = (v_r == 10'(V_TOTAL - 1));
        de_s     = (h_r < 11'(H_ACTIVE)) && (v_r < 10'(V_ACTIVE));
        hs_s     = (h_r >= 11'(H_ACTIVE + H_FP)) && (h_r < 11'(H_ACTIVE + H_FP + H_SYNC));
        vs_s     = (v_r >= 10'(V_ACTIVE + V_FP)) && (v_r < 10'(V_ACTIVE + V_FP + V_SYNC));
        cur_s    = {de_s, hs_s, vs_s};
    end

    assign pix_req     = de_s && en;
    assign pix_x       = h_r;
    assign pix_y       = v_r;
    assign frame_count = frame_count_r;
    assign VGA_H_SYNC  = hsync_r;
    assign VGA_V_SYNC  = vsync_r;
    assign VGA_R       = red_r;
    assign VGA_G       = grn_r;
    assign VGA_B       = blu_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;

    // Pixel-tick divider; holds while en is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r <= '0;
        end else if (tick_s) begin
            div_r <= '0;
        end else if (en) begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Horizontal/vertical position and completed-frame counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_r           <= 11'd0;
            v_r           <= 10'd0;
            frame_count_r <= 16'd0;
        end else if (tick_s) begin
            if (h_wrap_s) begin
                h_r <= 11'd0;
                if (v_wrap_s) begin
                    v_r           <= 10'd0;
                    frame_count_r <= frame_count_r + 16'd1;
                end else begin
                    v_r <= v_r + 10'd1;
                end
            end else begin
                h_r <= h_r + 11'd1;
            end
        end
    end

    // Strobes follow the counter directly, not the pixel pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            line_start_r  <= tick_s && h_wrap_s;
            frame_start_r <= tick_s && h_wrap_s && v_wrap_s;
        end
    end

    // {de,hs,vs} delayed by the source latency so they meet the returned colour
    generate
        if (PIPE == 0) begin : g_nopipe
            assign late_s = cur_s;
        end else begin : g_pipe
            logic [2:0] dly_r [PIPE];

            // Shift register advanced once per pixel tick
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < PIPE; i++) begin
                        dly_r[i] <= 3'b000;
                    end
                end else if (tick_s) begin
                    dly_r[0] <= cur_s;
                    for (int i = 1; i < PIPE; i++) begin
                        dly_r[i] <= dly_r[i-1];
                    end
                end
            end

            assign late_s = dly_r[PIPE-1];
        end
    endgenerate

    // VGA pin register; blanked with syncs idle while timing is disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync_r <= ~HS_POL;
            vsync_r <= ~VS_POL;
            red_r   <= '0;
            grn_r   <= '0;
            blu_r   <= '0;
        end else if (!en) begin
            hsync_r <= ~HS_POL;
            vsync_r <= ~VS_POL;
            red_r   <= '0;
            grn_r   <= '0;
            blu_r   <= '0;
        end else if (tick_s) begin
            hsync_r <= late_s[1] ? HS_POL : ~HS_POL;
            vsync_r <= late_s[0] ? VS_POL : ~VS_POL;
            red_r   <= late_s[2] ? pix_r : '0;
            grn_r   <= late_s[2] ? pix_g : '0;
            blu_r   <= late_s[2] ? pix_b : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: three small-raster instances covering
// PIPE=1/CLK_DIV=1, PIPE=0/CLK_DIV=3 with positive hsync, and PIPE=2.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic a_rst = 1'b0, b_rst = 1'b0, c_rst = 1'b0;
    logic a_en  = 1'b1, b_en  = 1'b1, c_en  = 1'b1;

    logic        a_req, b_req, c_req;
    logic [10:0] a_x, b_x, c_x;
    logic [9:0]  a_y, b_y, c_y;
    logic [3:0]  a_pr, a_pg, a_pb, b_pr, b_pg, b_pb, c_pr, c_pg, c_pb;
    logic        a_hs, a_vs, b_hs, b_vs, c_hs, c_vs;
    logic [3:0]  a_vr, a_vg, a_vb, b_vr, b_vg, b_vb, c_vr, c_vg, c_vb;
    logic        a_ls, a_fs, b_ls, b_fs, c_ls, c_fs;
    logic [15:0] a_fc, b_fc, c_fc;

    function automatic logic [11:0] colour(input logic [10:0] x, input logic [9:0] y);
        return {x[3:0], y[3:0], 4'hF};
    endfunction

    // Pixel sources: A returns one tick late, B combinationally, C two ticks late
    logic [11:0] a_src, c_s1, c_s2;
    always @(posedge clk) if (a_en) a_src <= colour(a_x, a_y);
    always @(posedge clk) if (c_en) begin c_s1 <= colour(c_x, c_y); c_s2 <= c_s1; end
    assign {a_pr, a_pg, a_pb} = a_src;
    assign {b_pr, b_pg, b_pb} = colour(b_x, b_y);
    assign {c_pr, c_pg, c_pb} = c_s2;

    int c_fs_seen = 0;
    always @(negedge clk) begin
        if (!c_rst) c_fs_seen <= 0;
        else if (c_fs) c_fs_seen <= c_fs_seen + 1;
    end

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .COLOR_W(4), .PIPE(1))
    u_a (.clk(clk), .rst(a_rst), .en(a_en), .pix_req(a_req), .pix_x(a_x), .pix_y(a_y),
        .pix_r(a_pr), .pix_g(a_pg), .pix_b(a_pb), .VGA_H_SYNC(a_hs), .VGA_V_SYNC(a_vs),
        .VGA_R(a_vr), .VGA_G(a_vg), .VGA_B(a_vb), .line_start(a_ls), .frame_start(a_fs),
        .frame_count(a_fc));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(3), .COLOR_W(4), .PIPE(0))
    u_b (.clk(clk), .rst(b_rst), .en(b_en), .pix_req(b_req), .pix_x(b_x), .pix_y(b_y),
        .pix_r(b_pr), .pix_g(b_pg), .pix_b(b_pb), .VGA_H_SYNC(b_hs), .VGA_V_SYNC(b_vs),
        .VGA_R(b_vr), .VGA_G(b_vg), .VGA_B(b_vb), .line_start(b_ls), .frame_start(b_fs),
        .frame_count(b_fc));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .COLOR_W(4), .PIPE(2))
    u_c (.clk(clk), .rst(c_rst), .en(c_en), .pix_req(c_req), .pix_x(c_x), .pix_y(c_y),
        .pix_r(c_pr), .pix_g(c_pg), .pix_b(c_pb), .VGA_H_SYNC(c_hs), .VGA_V_SYNC(c_vs),
        .VGA_R(c_vr), .VGA_G(c_vg), .VGA_B(c_vb), .line_start(c_ls), .frame_start(c_fs),
        .frame_count(c_fc));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_a(input int x, input int y);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(a_x == 11'(x) && a_y == 10'(y)) && n < 300);
        chk("a_wait_xy", {a_x, a_y}, {11'(x), 10'(y)});
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n, hs_low, vs_low, ls_cnt, fs_cnt, hs_high;

        @(negedge clk); @(negedge clk);
        chk("a_rst_out", {a_vr, a_vg, a_vb, a_hs, a_vs, a_ls, a_fs, a_fc}, {12'h000, 2'b11, 2'b00, 16'd0});
        chk("b_rst_out", {b_vr, b_vg, b_vb, b_hs, b_vs, b_ls, b_fs, b_fc}, {12'h000, 2'b01, 2'b00, 16'd0});
        chk("c_rst_out", {c_vr, c_vg, c_vb, c_hs, c_vs, c_ls, c_fs, c_fc}, {12'h000, 2'b11, 2'b00, 16'd0});
        chk("a_rst_xy", {a_x, a_y, a_req}, {11'd0, 10'd0, 1'b1});
        chk("b_rst_xy", {b_x, b_y, b_req}, {11'd0, 10'd0, 1'b1});
        chk("c_rst_xy", {c_x, c_y, c_req}, {11'd0, 10'd0, 1'b1});
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;

        // First frame after reset: 98 clks, simultaneous strobes, count 1
        n = 0;
        do begin @(negedge clk); n++; end while (!a_fs && n < 300);
        chk("a_first_frame", n, 98);
        chk("a_wrap_strobes", {a_ls, a_fs}, 2'b11);
        chk("a_fc1", a_fc, 16'd1);

        // One full frame: line/frame periods and sync widths
        vs_low = 0; ls_cnt = 0; fs_cnt = 0;
        for (int l = 0; l < 7; l++) begin
            hs_low = 0;
            for (int k = 0; k < 14; k++) begin
                @(negedge clk);
                if (!a_hs) hs_low++;
                if (!a_vs) vs_low++;
                if (a_ls) ls_cnt++;
                if (a_fs) fs_cnt++;
            end
            chk("a_hs_low", hs_low, 2);
            chk("a_line_period", a_ls, 1);
        end
        chk("a_vs_low", vs_low, 14);
        chk("a_ls_count", ls_cnt, 7);
        chk("a_fs_count", fs_cnt, 1);
        chk("a_frame_period", a_fs, 1);
        chk("a_fc2", a_fc, 16'd2);

        n = 0;
        do begin @(negedge clk); n++; end while (!a_fs && n < 300);
        chk("a_frame3_period", n, 98);
        chk("a_fc3", a_fc, 16'd3);

        // Source latency: (5,2) lands two samples after it is requested
        wait_a(5, 2);
        @(negedge clk); chk("a_pix_4_2", {a_vr, a_vg, a_vb}, 12'h42F);
        @(negedge clk); chk("a_pix_5_2", {a_vr, a_vg, a_vb}, 12'h52F);

        // Horizontal blanking h=8..13 on line 1, framed by active pixels
        wait_a(8, 1);
        @(negedge clk); chk("a_pix_7_1", {a_vr, a_vg, a_vb}, 12'h71F);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); chk("a_hblank", {a_vr, a_vg, a_vb}, 12'h000);
        end
        @(negedge clk); chk("a_pix_0_2", {a_vr, a_vg, a_vb}, 12'h02F);

        // Enable gap of 20 clks at h=4
        wait_a(4, 1);
        a_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("a_en_gap", {a_x, a_req, a_vr, a_vg, a_vb, a_hs, a_vs, a_ls, a_fs},
                {11'd4, 1'b0, 12'h000, 2'b11, 2'b00});
        end
        a_en = 1'b1;
        ls_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) chk("a_resume_x", a_x, 11'd5);
            if (a_ls) ls_cnt++;
        end
        chk("a_resume_ls", {a_ls, a_x, a_y}, {1'b1, 11'd0, 10'd2});
        chk("a_resume_ls_cnt", ls_cnt, 1);

        // CLK_DIV=3: one pixel per 3 clks, hsync high 6 clks, 42-clk line
        n = 0;
        do begin @(negedge clk); n++; end while (!b_ls && n < 200);
        chk("b_found_ls", b_ls, 1);
        hs_high = 0; ls_cnt = 0;
        for (int i = 1; i <= 42; i++) begin
            @(negedge clk);
            if (i < 42) chk("b_pix_x", b_x, i / 3);
            if (b_hs) hs_high++;
            if (b_ls) ls_cnt++;
        end
        chk("b_line_period", b_ls, 1);
        chk("b_ls_count", ls_cnt, 1);
        chk("b_hs_high", hs_high, 6);

        // Asynchronous reset mid-frame on the PIPE=2 instance
        n = 0;
        do begin @(negedge clk); n++; end while (!(c_x == 11'd6 && c_y == 10'd3) && n < 400);
        chk("c_pix_3_3", {c_vr, c_vg, c_vb}, 12'h33F);
        chk("c_fc_pre", c_fc, c_fs_seen);
        c_rst = 1'b0;
        #1;
        chk("c_async_out", {c_vr, c_vg, c_vb, c_hs, c_vs, c_ls, c_fs, c_fc}, {12'h000, 2'b11, 2'b00, 16'd0});
        chk("c_async_xy", {c_x, c_y}, {11'd0, 10'd0});
        @(negedge clk); @(negedge clk);
        c_rst = 1'b1;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (n == 1) chk("c_flush1", {c_vr, c_vg, c_vb, c_hs}, {12'h000, 1'b1});
            if (n == 2) chk("c_flush2", {c_vr, c_vg, c_vb}, 12'h000);
            if (n == 3) chk("c_first_pix", {c_vr, c_vg, c_vb}, 12'h00F);
        end while (!c_fs && n < 300);
        chk("c_first_frame", n, 98);
        chk("c_fc1", c_fc, 16'd1);

        // frame_count wrap from 65535
        force u_c.frame_count_r = 16'hFFFF;
        @(negedge clk);
        release u_c.frame_count_r;
        chk("c_fc_forced", c_fc, 16'hFFFF);
        n = 0; fs_cnt = 0;
        do begin @(negedge clk); n++; if (c_fs) fs_cnt++; end
        while (c_fc != 16'd0 && n < 300);
        chk("c_wrap_len", n, 97);
        chk("c_wrap_fs", {c_fs, c_fc}, {1'b1, 16'd0});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (c_fs) fs_cnt++;
        end
        chk("c_wrap_fs_once", fs_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
